// File: rtl/logic_ctrl_pkg.sv
// Shared Logic_Ctrl definitions: channel limits, arbiter state
// encodings and the default engine timeout.
package logic_ctrl_pkg;

  localparam int N_CH_MAX    = 8;
  localparam int TMO_CYC_DEF = 50000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic int wrap_inc(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate by pointer, take lowest set bit,
// rotate the index back.
module rr_pick #(
  parameter int N_CH = 8,
  parameter int CH_W = 3
) (
  input  logic [N_CH-1:0] elig,
  input  logic [CH_W-1:0] rr_ptr,
  output logic            valid,
  output logic [CH_W-1:0] idx
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [CH_W-1:0]   off;
  logic [CH_W:0]     sum;

  always_comb begin
    dbl   = {elig, elig};
    rot   = dbl[rr_ptr +: N_CH];
    valid = |rot;
    off   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) off = CH_W'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (CH_W + 1)'(N_CH))
      idx = CH_W'(sum - (CH_W + 1)'(N_CH));
    else
      idx = sum[CH_W-1:0];
  end

endmodule

// File: rtl/logic_wave_arb.sv
// Round-robin scheduler sharing one wave engine between the
// Logic_Ctrl channels, with overrun and timeout reporting.
module logic_wave_arb
  import logic_ctrl_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int CH_W    = 3,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] wave_req,
  input  logic [N_CH-1:0] ch_enable,
  input  logic            wave_done,
  input  logic            clr_err,
  output logic            wave_start,
  output logic [CH_W-1:0] wave_ch,
  output logic            wave_busy,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] ovr_err,
  output logic [N_CH-1:0] tmo_err
);

  state_e          state_q;
  logic            arm_q;
  logic            start_q;
  logic            busy_q;
  logic [CH_W-1:0] ch_q;
  logic [CH_W-1:0] ptr_q;
  logic [TMO_W-1:0] cnt_q;
  logic [N_CH-1:0] req_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovr_q, ovr_d;
  logic [N_CH-1:0] tmo_q, tmo_d;
  logic [N_CH-1:0] req_edge;
  logic [N_CH-1:0] gnt_mask;
  logic [N_CH-1:0] tmo_set;
  logic [CH_W-1:0] pick_idx;
  logic            pick_vld;
  logic            grant;
  logic            tmo_hit;

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .elig   (pend_q & ch_enable),
    .rr_ptr (ptr_q),
    .valid  (pick_vld),
    .idx    (pick_idx)
  );

  always_comb begin
    grant    = (state_q == ST_IDLE) & pick_vld;
    gnt_mask = '0;
    if (grant) gnt_mask[pick_idx] = 1'b1;
    // arm_q masks the first cycle out of reset so held levels are not edges
    req_edge = wave_req & ~req_q & {N_CH{arm_q}};
    tmo_hit  = (state_q == ST_WAIT) & ~wave_done
             & (cnt_q == TMO_W'(TMO_CYC - 1));
    tmo_set  = '0;
    if (tmo_hit) tmo_set[ch_q] = 1'b1;
    pend_d = (pend_q & ~gnt_mask) | req_edge;
    ovr_d  = (ovr_q & ~{N_CH{clr_err}})
           | (req_edge & pend_q & ~gnt_mask);
    tmo_d  = (tmo_q & ~{N_CH{clr_err}}) | tmo_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arm_q  <= 1'b0;
      req_q  <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
      tmo_q  <= '0;
    end else begin
      arm_q  <= 1'b1;
      req_q  <= wave_req;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      tmo_q  <= tmo_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q <= ST_START;
            ch_q    <= pick_idx;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + TMO_W'(1);
          if (wave_done | tmo_hit) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= CH_W'(wrap_inc(int'(ch_q), N_CH));
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wave_start = start_q;
  assign wave_ch    = ch_q;
  assign wave_busy  = busy_q;
  assign pending    = pend_q;
  assign ovr_err    = ovr_q;
  assign tmo_err    = tmo_q;

endmodule

// File: tb/tb_logic_wave_arb.sv
// Directed bench for logic_wave_arb: grant order, overrun,
// timeout, enable masking and async reset.
module tb_logic_wave_arb;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] wave_req = '0;
  logic [7:0] ch_enable = 8'hFF;
  logic       wave_done = 1'b0;
  logic       clr_err = 1'b0;
  logic       wave_start;
  logic [2:0] wave_ch;
  logic       wave_busy;
  logic [7:0] pending;
  logic [7:0] ovr_err;
  logic [7:0] tmo_err;

  int n_chk = 0;
  int n_err = 0;

  logic_wave_arb #(
    .N_CH    (8),
    .CH_W    (3),
    .TMO_W   (16),
    .TMO_CYC (16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wave_req   (wave_req),
    .ch_enable  (ch_enable),
    .wave_done  (wave_done),
    .clr_err    (clr_err),
    .wave_start (wave_start),
    .wave_ch    (wave_ch),
    .wave_busy  (wave_busy),
    .pending    (pending),
    .ovr_err    (ovr_err),
    .tmo_err    (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_pulse(input logic [7:0] m);
    wave_req = wave_req | m;
    tick();
    wave_req = wave_req & ~m;
  endtask

  task automatic done_pulse();
    wave_done = 1'b1;
    tick();
    wave_done = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (wave_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("start_seen", {31'd0, wave_start}, 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    tick();
  endtask

  task automatic count_starts(input int cyc, output int n);
    n = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (wave_start === 1'b1) n++;
    end
  endtask

  initial begin
    int ns;
    logic [2:0] order [4];
    order = '{3'd0, 3'd3, 3'd5, 3'd0};

    // 1: reset values, single grant, pointer advance
    #2;
    chk("rst_start", {31'd0, wave_start}, 0);
    chk("rst_busy", {31'd0, wave_busy}, 0);
    chk("rst_outs", {8'd0, pending, ovr_err, tmo_err}, 0);
    chk("rst_ch", {29'd0, wave_ch}, 0);
    do_reset();
    req_pulse(8'h04);
    chk("t1_pend", {24'd0, pending}, 32'h04);
    chk("t1_nostart", {31'd0, wave_start}, 0);
    tick();
    chk("t1_start", {31'd0, wave_start}, 1);
    chk("t1_ch", {29'd0, wave_ch}, 2);
    chk("t1_pend0", {24'd0, pending}, 0);
    chk("t1_busy", {31'd0, wave_busy}, 1);
    tick();
    chk("t1_pulse1", {31'd0, wave_start}, 0);
    repeat (8) tick();
    done_pulse();
    chk("t1_idle", {31'd0, wave_busy}, 0);
    req_pulse(8'h0A);
    tick();
    chk("t1_ptr3", {29'd0, wave_ch}, 3);
    tick();
    done_pulse();
    chk("t1_gap", {31'd0, wave_start}, 0);
    tick();
    chk("t1_ch1_st", {31'd0, wave_start}, 1);
    chk("t1_ch1", {29'd0, wave_ch}, 1);
    tick();
    done_pulse();

    // 2: simultaneous requests served in rotation
    do_reset();
    req_pulse(8'h29);
    for (int i = 0; i < 4; i++) begin
      wait_start(6);
      chk("t2_order", {29'd0, wave_ch}, {29'd0, order[i]});
      if (i == 0) req_pulse(8'h01);
      else tick();
      tick();
      tick();
      done_pulse();
    end
    chk("t2_pend", {24'd0, pending}, 0);
    chk("t2_ovr", {24'd0, ovr_err}, 0);

    // 3: overrun, clear priority, single service
    do_reset();
    ch_enable = 8'hFD;
    req_pulse(8'h02);
    tick();
    req_pulse(8'h02);
    chk("t3_ovr", {24'd0, ovr_err}, 32'h02);
    chk("t3_pend", {24'd0, pending}, 32'h02);
    tick();
    clr_err = 1'b1;
    req_pulse(8'h02);
    clr_err = 1'b0;
    chk("t3_setwins", {24'd0, ovr_err}, 32'h02);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_clr", {24'd0, ovr_err}, 0);
    ch_enable = 8'hFF;
    wait_start(4);
    chk("t3_ch", {29'd0, wave_ch}, 1);
    tick();
    done_pulse();
    count_starts(8, ns);
    chk("t3_once", ns, 0);
    chk("t3_pend0", {24'd0, pending}, 0);

    // 4: timeout, then done racing the terminal count
    do_reset();
    req_pulse(8'h10);
    tick();
    chk("t4_ch4", {29'd0, wave_ch}, 4);
    req_pulse(8'h44);
    repeat (15) tick();
    chk("t4_pre_tmo", {24'd0, tmo_err}, 0);
    chk("t4_pre_busy", {31'd0, wave_busy}, 1);
    tick();
    chk("t4_tmo", {24'd0, tmo_err}, 32'h10);
    chk("t4_idle", {31'd0, wave_busy}, 0);
    tick();
    chk("t4_next", {29'd0, wave_ch}, 6);
    repeat (16) tick();
    done_pulse();
    chk("t4_donewins", {24'd0, tmo_err}, 32'h10);
    chk("t4_idle2", {31'd0, wave_busy}, 0);
    tick();
    chk("t4_ch2", {29'd0, wave_ch}, 2);
    chk("t4_st2", {31'd0, wave_start}, 1);
    tick();
    done_pulse();

    // 5: disabled channel keeps its pending bit
    do_reset();
    ch_enable = 8'hFE;
    req_pulse(8'h03);
    tick();
    chk("t5_ch1", {29'd0, wave_ch}, 1);
    chk("t5_pend", {24'd0, pending}, 32'h01);
    tick();
    done_pulse();
    tick();
    tick();
    chk("t5_hold", {24'd0, pending}, 32'h01);
    chk("t5_nost", {31'd0, wave_start}, 0);
    ch_enable = 8'hFF;
    tick();
    chk("t5_ch0_st", {31'd0, wave_start}, 1);
    chk("t5_ch0", {29'd0, wave_ch}, 0);
    ch_enable = 8'h00;
    tick();
    done_pulse();
    chk("t5_done", {31'd0, wave_busy}, 0);
    ch_enable = 8'hFF;

    // 6: async reset mid-transfer with levels held high
    do_reset();
    req_pulse(8'h10);
    tick();
    req_pulse(8'h0C);
    chk("t6_pend", {24'd0, pending}, 32'h0C);
    wave_req = 8'h0C;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_busy", {31'd0, wave_busy}, 0);
    chk("t6_outs", {8'd0, pending, ovr_err, tmo_err}, 0);
    chk("t6_ch", {29'd0, wave_ch}, 0);
    tick();
    tick();
    rstn = 1'b1;
    count_starts(8, ns);
    chk("t6_nostart", ns, 0);
    chk("t6_pend0", {24'd0, pending}, 0);
    wave_req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
